adder_nbit_inverse: RTL

Sequential bit-serial operand recovery unit, the inverse of the N-bit adder: given a sum and one operand, it returns the other operand, b = sum − a. One bit per clock, LSB first, with a start/busy/done handshake. It sits beside `adder_nbit` in the arithmetic datapath and in self-checking benches, where it closes the loop on adder results.

---
 rtl/adder_nbit_inverse_pkg.sv | 15 +
 rtl/adder_nbit_inverse_full_sub_1bit.sv | 22 ++
 rtl/adder_nbit_inverse.sv | 108 ++++++++++
 3 files changed

// File: rtl/adder_nbit_inverse_pkg.sv
// adder_nbit_inverse_pkg
//   Shared definitions for the bit-serial operand recovery unit.
//   - inv_state_t : FSM state encoding (IDLE/RUN/DONE)
//   - INV_DEFAULT_N : default operand width
package adder_nbit_inverse_pkg;

    localparam int INV_DEFAULT_N = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } inv_state_t;

endpackage

// File: rtl/adder_nbit_inverse_full_sub_1bit.sv
// full_sub_1bit
//   One-bit full subtractor: d = m - s - bin.
//   Ports:
//     m    in  minuend bit
//     s    in  subtrahend bit
//     bin  in  borrow in
//     d    out difference bit
//     bout out borrow out
module full_sub_1bit (
    input  logic m,
    input  logic s,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = m ^ s ^ bin;
    // Borrow when the subtrahend bit exceeds the minuend bit, or when the
    // bits are equal and a borrow is already pending.
    assign bout = (~m & s) | (~(m ^ s) & bin);

endmodule

// File: rtl/adder_nbit_inverse.sv
// adder_nbit_inverse
//   Bit-serial operand recovery: b = (sum - {0,a}) mod 2^(N+1), one bit per
//   clock, LSB first.
//   Ports:
//     clk       in   clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     start     in   request, sampled only in IDLE
//     sum       in   [N:0]   minuend, captured on acceptance
//     a         in   [N-1:0] subtrahend, captured on acceptance
//     b         out  [N:0]   recovered operand, held until next completion
//     underflow out  final borrow (sum < a)
//     busy      out  high while the serial loop is running
//     done      out  one-cycle completion pulse
//
//   Handshake: a request is accepted on any rising edge where start=1 and
//   the unit is idle (busy=0, done=0); start at any other time is dropped,
//   never queued. Acceptance raises busy on that same edge; N+1 edges later
//   busy falls and done pulses for one cycle with b/underflow valid.
module adder_nbit_inverse
    import adder_nbit_inverse_pkg::*;
#(
    parameter int N = INV_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N:0]   sum,
    input  logic [N-1:0] a,
    output logic [N:0]   b,
    output logic         underflow,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    inv_state_t     state;
    logic [N:0]     m_sh;    // minuend, shifted right each RUN cycle
    logic [N:0]     s_sh;    // subtrahend zero-extended so bit N subtracts 0
    logic [N:0]     res_sh;  // difference bits enter at the MSB
    logic           br;
    logic [CW-1:0]  cnt;
    logic           d_bit;
    logic           bout;

    full_sub_1bit u_sub (
        .m    (m_sh[0]),
        .s    (s_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            m_sh      <= '0;
            s_sh      <= '0;
            res_sh    <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            b         <= '0;
            underflow <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_sh  <= sum;
                        s_sh  <= {1'b0, a};
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    m_sh   <= m_sh >> 1;
                    s_sh   <= s_sh >> 1;
                    res_sh <= {d_bit, res_sh[N:1]};
                    br     <= bout;
                    if (cnt == CW'(N)) begin
                        // Last bit: the shifted-in value is the full result.
                        b         <= {d_bit, res_sh[N:1]};
                        underflow <= bout;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
